// File: rtl/gat_feat_readback.sv
// gat_feat_readback: host-side reader for the GAT new-feature BRAM port.
// Waits for gat_ready, sweeps a word range of the feature BRAM, buffers the
// read data in a credit-controlled FIFO and streams it out with valid/ready.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request (sampled only when idle)
//   rd_base, rd_len     first word index and word count
//   gat_ready           accelerator results valid
//   feat_bram_addrb     BRAM byte address (bits[1:0] = 0)
//   feat_bram_dout      BRAM read data, RD_LAT cycles after the address
//   m_tdata/m_tvalid/m_tready/m_tlast  output stream
//   busy, done, err     status: not idle, completion pulse, sticky range error
module gat_feat_readback #(
    parameter int NEW_FEATURE_WIDTH  = 32,
    parameter int NEW_FEATURE_DEPTH  = 43328,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int RD_LAT             = 2,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NEW_FEATURE_ADDR_W-1:0] rd_base,
    input  logic [NEW_FEATURE_ADDR_W:0]   rd_len,
    input  logic                          gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    localparam int AW = NEW_FEATURE_ADDR_W;
    localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] ONE = 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0]   base_q;
    logic [AW:0]     len_q;
    logic [AW:0]     last_idx;
    logic [AW:0]     issue_cnt;
    logic [AW:0]     out_cnt;
    logic [AW+1:0]   addr_q;
    logic [AW+1:0]   range_end;
    logic [AW-1:0]   word_addr;
    logic [RD_LAT-1:0] vld_sr;
    logic [NEW_FEATURE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   inflight;
    logic            credit, issue, push, pop, range_bad, err_set;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // One bit per outstanding BRAM read; its popcount is the in-flight total.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(vld_sr[i]);
        end
    end

    // Range check carries two extra bits so base+len can never wrap.
    assign range_end = {2'b00, base_q} + {1'b0, len_q};
    assign range_bad = range_end > (AW+2)'(NEW_FEATURE_DEPTH);
    assign last_idx  = len_q - ONE;
    assign word_addr = base_q + issue_cnt[AW-1:0];

    assign credit = (fifo_count + inflight) < CW'(FIFO_DEPTH);
    assign push   = vld_sr[RD_LAT-1];
    assign pop    = m_tvalid && m_tready;

    // Address is live in the issue cycle, otherwise the last issued value.
    assign feat_bram_addrb = issue ? {word_addr, 2'b00} : addr_q;

    assign m_tvalid = (fifo_count != '0);
    assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;
    assign m_tlast  = m_tvalid && (out_cnt == last_idx);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done      = 1'b0;
        err_set   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (len_q == '0) begin
                    state_nxt = DONE;
                end else if (range_bad) begin
                    err_set   = 1'b1;
                    state_nxt = DONE;
                end else if (gat_ready) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (credit) begin
                    issue = 1'b1;
                    if (issue_cnt == last_idx) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as the last word is handed off so done follows it
                // by exactly one cycle.
                if (inflight == '0 &&
                    (fifo_count == '0 ||
                     (fifo_count == CW'(1) && pop))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issue_cnt  <= '0;
            out_cnt    <= '0;
            addr_q     <= '0;
            err        <= 1'b0;
            vld_sr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                base_q    <= rd_base;
                len_q     <= rd_len;
                issue_cnt <= '0;
                out_cnt   <= '0;
                err       <= 1'b0;
            end
            if (err_set) err <= 1'b1;
            if (issue) begin
                issue_cnt <= issue_cnt + ONE;
                addr_q    <= feat_bram_addrb;
            end
            vld_sr[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
            if (push) begin
                mem[wr_ptr] <= feat_bram_dout;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr  <= ptr_inc(rd_ptr);
                out_cnt <= out_cnt + ONE;
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

endmodule
